dcache_dm: RTL and testbench

- Parametrised direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipelined core's memory stage (MemWriteM, ALUResult address, WriteData, ReadData) and a backing data memory with variable latency.
- Replaces the single-cycle data memory path: hits return data combinationally; misses and writes raise a stall.
- Backing memory is reached through a req/ready handshake, one word per beat.

---
 rtl/dcache_pkg.sv | 25 ++
 rtl/dcache_data_array.sv | 28 ++
 rtl/dcache_dm.sv | 197 +++++++++++++++++++
 tb/tb_dcache_dm.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } state_t;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - $clog2(WORD_BYTES) - $clog2(words_per_line) - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Line data storage: one synchronous write port, one asynchronous read port.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                             clk,
  input  logic                             i_we,
  input  logic [idx_w(LINES)-1:0]          i_wline,
  input  logic [off_w(WORDS_PER_LINE)-1:0] i_wword,
  input  logic [31:0]                      i_wd,
  input  logic [idx_w(LINES)-1:0]          i_rline,
  input  logic [off_w(WORDS_PER_LINE)-1:0] i_rword,
  output logic [31:0]                      o_rd
);

  logic [31:0] r_mem [LINES*WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[{i_wline, i_wword}] <= i_wd;
    end
  end

  assign o_rd = r_mem[{i_rline, i_rword}];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a one-word-per-beat
// backing-memory handshake. Define CACHE_STATS_EN to build saturating load hit/miss counters.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wd,
  output logic [31:0]       cpu_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  input  logic              mem_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int BYTE_W = $clog2(WORD_BYTES);
  localparam int OFF_W  = off_w(WORDS_PER_LINE);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(WORDS_PER_LINE - 1);

  state_t            r_state, w_next;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag [LINES];
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wd;
  logic [OFF_W-1:0]  r_beat;

  logic [OFF_W-1:0]  w_off, w_m_off, w_arr_word;
  logic [IDX_W-1:0]  w_idx, w_m_idx;
  logic [TAG_W-1:0]  w_tag, w_m_tag;
  logic              w_hit, w_m_hit, w_stall, w_arr_we, w_last_beat, w_unused;
  logic [31:0]       w_arr_wd, w_arr_rd;

  assign w_off   = cpu_addr[BYTE_W +: OFF_W];
  assign w_idx   = cpu_addr[BYTE_W+OFF_W +: IDX_W];
  assign w_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // In-flight transactions are tracked through the registered beat address,
  // so the line being filled or written does not depend on cpu_addr holding still.
  assign w_m_off = r_mem_addr[BYTE_W +: OFF_W];
  assign w_m_idx = r_mem_addr[BYTE_W+OFF_W +: IDX_W];
  assign w_m_tag = r_mem_addr[ADDR_W-1 -: TAG_W];
  assign w_m_hit = r_valid[w_m_idx] && (r_tag[w_m_idx] == w_m_tag);

  assign w_last_beat = (r_state == REFILL) && mem_ready && (r_beat == BEAT_LAST);
  assign w_unused    = ^{cpu_addr[BYTE_W-1:0], r_mem_addr[BYTE_W-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cpu_we) w_next = WRITE;
               else if (cpu_re && !w_hit) w_next = REFILL;
      REFILL:  if (w_last_beat) w_next = IDLE;
      WRITE:   if (mem_ready) w_next = WDONE;
      WDONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    cpu_rd  = '0;
    case (r_state)
      IDLE: begin
        w_stall = cpu_we || (cpu_re && !w_hit);
        cpu_rd  = w_arr_rd;
      end
      REFILL, WRITE: w_stall = 1'b1;
      default:       w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
      r_beat     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_we) begin
            r_mem_addr <= {cpu_addr[ADDR_W-1:BYTE_W], {BYTE_W{1'b0}}};
            r_mem_wd   <= cpu_wd;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b1;
          end else if (cpu_re && !w_hit) begin
            r_mem_addr <= {cpu_addr[ADDR_W-1:BYTE_W+OFF_W], {(BYTE_W+OFF_W){1'b0}}};
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_beat     <= '0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            r_beat     <= r_beat + 1'b1;
            r_mem_addr <= r_mem_addr + ADDR_W'(WORD_BYTES);
            if (r_beat == BEAT_LAST) begin
              r_valid[w_m_idx] <= 1'b1;
              r_mem_req        <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_last_beat) r_tag[w_m_idx] <= w_m_tag;
  end

  // Refill beats and write hits share the single array write port; they never overlap.
  always_comb begin
    w_arr_we   = 1'b0;
    w_arr_word = r_beat;
    w_arr_wd   = mem_rd;
    if (r_state == REFILL) begin
      w_arr_we = mem_ready;
    end else if (r_state == WRITE && w_m_hit) begin
      w_arr_we   = mem_ready;
      w_arr_word = w_m_off;
      w_arr_wd   = r_mem_wd;
    end
  end

  dcache_data_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_wline (w_m_idx),
    .i_wword (w_arr_word),
    .i_wd    (w_arr_wd),
    .i_rline (w_idx),
    .i_rword (w_off),
    .o_rd    (w_arr_rd)
  );

  assign stall    = w_stall;
  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_wd   = r_mem_wd;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == IDLE && cpu_re && !cpu_we && w_hit && !w_stall && r_hit_cnt != '1)
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (r_state == IDLE && w_next == REFILL && r_miss_cnt != '1)
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed scenarios plus randomized traffic
// against a line-level cache model and a shadow of the backing memory.
module tb_dcache_dm;

  localparam int LINES = 16;
  localparam int WPL   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_ready;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_dm #(.LINES(LINES), .WORDS_PER_LINE(WPL), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Backing memory slave: mode 0 zero-wait, 1 ready every 3rd cycle, 2 random.
  int mode = 0;
  int rcnt = 0;
  always @(negedge clk) begin
    rcnt <= rcnt + 1;
    case (mode)
      1:       mem_ready <= (rcnt % 3 == 2);
      2:       mem_ready <= ($urandom_range(0, 2) == 0);
      default: mem_ready <= 1'b1;
    endcase
  end

  function automatic logic [31:0] base_word(input logic [31:0] a);
    if (a[11:2] == 10'h010) return 32'hDEADBEEF;
    return ({20'h0, a[11:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  logic [31:0] ov_data [1024];
  bit          ov_valid [1024];
  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) begin
      ov_valid[mem_addr[11:2]] <= 1'b1;
      ov_data[mem_addr[11:2]]  <= mem_wd;
    end
  end
  always_comb begin
    mem_rd = ov_valid[mem_addr[11:2]] ? ov_data[mem_addr[11:2]] : base_word(mem_addr);
  end

  // Reference: shadow memory written by the bench's own stores, plus line tags.
  logic [31:0] exp_mem [1024];
  bit          exp_set [1024];
  bit          mv [LINES];
  int unsigned mt [LINES];
  int unsigned exp_hits = 0;
  int unsigned exp_miss = 0;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return exp_set[a[11:2]] ? exp_mem[a[11:2]] : base_word(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input bit zero_wait);
    int unsigned li, tg;
    bit pred_hit, pend;
    int cyc, beats;
    logic [31:0] base, paddr;
    li = (a >> 4) % LINES;
    tg = a >> 8;
    pred_hit = mv[li] && (mt[li] == tg);
    base = a & ~32'hF;
    @(negedge clk);
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1;
    check("rd_first_stall", 32'(stall), 32'(!pred_hit));
    cyc = 0; beats = 0; pend = 1'b0; paddr = '0;
    while (stall && cyc < 300) begin
      if (pend) begin
        check("rd_hold_req", 32'(mem_req), 32'd1);
        check("rd_hold_addr", mem_addr, paddr);
      end
      if (mem_req && mem_ready) begin
        check("rd_beat_addr", mem_addr, base + 32'(4 * beats));
        check("rd_beat_we", 32'(mem_we), 32'd0);
        beats++;
      end
      pend = mem_req && !mem_ready;
      paddr = mem_addr;
      @(negedge clk); #1;
      cyc++;
    end
    check("rd_timeout", 32'(cyc < 300), 32'd1);
    check("rd_beats", 32'(beats), pred_hit ? 32'd0 : 32'(WPL));
    if (zero_wait) check("rd_stall_cycles", 32'(cyc), pred_hit ? 32'd0 : 32'(1 + WPL));
    check("rd_data", cpu_rd, exp_word(a));
    check("rd_done_req", 32'(mem_req), 32'd0);
    mv[li] = 1'b1;
    mt[li] = tg;
    exp_hits++;
    if (!pred_hit) exp_miss++;
    $display("read  addr=%h hit=%0d stall=%0d data=%h", a, pred_hit, cyc, cpu_rd);
    @(negedge clk);
    cpu_re = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit zero_wait);
    int cyc, reqs;
    bit pend;
    logic [31:0] paddr;
    @(negedge clk);
    cpu_we = 1'b1; cpu_re = 1'($urandom_range(0, 1)); cpu_addr = a; cpu_wd = d;
    #1;
    check("wr_first_stall", 32'(stall), 32'd1);
    check("wr_first_req", 32'(mem_req), 32'd0);
    cyc = 0; reqs = 0; pend = 1'b0; paddr = '0;
    while (stall && cyc < 300) begin
      if (pend) check("wr_hold_addr", mem_addr, paddr);
      if (mem_req) begin
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", mem_addr, a & ~32'h3);
        check("wr_mem_wd", mem_wd, d);
        reqs++;
      end
      pend = mem_req && !mem_ready;
      paddr = mem_addr;
      @(negedge clk); #1;
      cyc++;
    end
    check("wr_timeout", 32'(cyc < 300), 32'd1);
    check("wr_req_seen", 32'(reqs > 0), 32'd1);
    if (zero_wait) check("wr_stall_cycles", 32'(cyc), 32'd2);
    check("wr_wdone_req", 32'(mem_req), 32'd0);
    exp_mem[a[11:2]] = d;
    exp_set[a[11:2]] = 1'b1;
    $display("write addr=%h data=%h stall=%0d", a, d, cyc);
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  initial begin
    int cyc, beats;
    bit pend;
    logic [31:0] paddr, a, d;

    reset = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
    for (int i = 0; i < LINES; i++) begin mv[i] = 1'b0; mt[i] = 0; end
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_miss", miss_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed scenarios with zero-wait memory.
    do_read(32'h40, 1'b1);
    do_read(32'h48, 1'b1);
    do_write(32'h44, 32'h12345678, 1'b1);
    do_read(32'h44, 1'b1);
    do_write(32'h400, 32'hCAFEF00D, 1'b1);
    do_read(32'h400, 1'b1);
    do_read(32'h440, 1'b1);
    do_read(32'h40, 1'b1);
    do_read(32'h440, 1'b1);

    // Slow refill interrupted by reset after the second beat.
    mode = 1;
    @(negedge clk);
    cpu_re = 1'b1; cpu_addr = 32'h880;
    #1;
    cyc = 0; beats = 0; pend = 1'b0; paddr = '0;
    while (beats < 2 && cyc < 100) begin
      if (pend) begin
        check("slow_hold_req", 32'(mem_req), 32'd1);
        check("slow_hold_addr", mem_addr, paddr);
      end
      if (mem_req && mem_ready) beats++;
      pend = mem_req && !mem_ready;
      paddr = mem_addr;
      @(negedge clk); #1;
      cyc++;
    end
    check("slow_timeout", 32'(cyc < 100), 32'd1);
    check("slow_req_mid", 32'(mem_req), 32'd1);
    check("slow_addr_mid", mem_addr, 32'h888);
    reset = 1'b1;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_hits", hit_count, 32'd0);
    check("arst_miss", miss_count, 32'd0);
    cpu_re = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    $display("reset asserted mid-refill after %0d beats", beats);
    @(negedge clk);
    reset = 1'b0;
    mode = 0;
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    do_read(32'h880, 1'b1);
    do_read(32'h40, 1'b1);

    // Randomized traffic with random memory latency.
    mode = 2;
    for (int n = 0; n < 60; n++) begin
      a = {20'h0, 10'($urandom_range(0, 511)), 2'b00};
      d = $urandom;
      if ($urandom_range(0, 9) < 3) do_write(a, d, 1'b0);
      else                          do_read(a, 1'b0);
    end

`ifdef CACHE_STATS_EN
    check("stat_hits", hit_count, 32'(exp_hits));
    check("stat_miss", miss_count, 32'(exp_miss));
`else
    check("stat_hits_tied", hit_count, 32'd0);
    check("stat_miss_tied", miss_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
